uart_cmd_decoder: RTL and testbench
===================================

Name: uart_cmd_decoder

Overview:
Consumes the byte stream from the UART receiver (one-cycle rx_valid pulses) and parses framed command packets. Each valid packet becomes a single register-write transaction on a valid/ready write port to the configuration register bank. It sits between the UART receiver and the control/status registers. It is the only path by which the host configures the hardware over the serial link.

Parameters:
SYNC_BYTE, 8'hA5, packet start marker
DATA_BYTES, 2, payload bytes per packet (1..4); write data width = 8*DATA_BYTES
TIMEOUT_CLKS, 50000, idle clocks allowed between bytes inside a packet (used only with the optional feature)

Ports:
clk  input  1  system clock
reset_n  input  1  reset, asynchronous, active-low
rx_byte  input  8  received byte from UART receiver
rx_valid  input  1  one-cycle pulse; rx_byte is valid while high
reg_wr_en  output  1  write request; held until accepted
reg_addr  output  8  register address
reg_wr_data  output  8*DATA_BYTES  write data
reg_wr_ready  input  1  register bank accepts the write when high with reg_wr_en
pkt_err  output  1  one-cycle pulse on any packet error
err_count  output  8  saturating error counter
busy  output  1  high in any state other than IDLE

Behaviour:
- Packet format: SYNC_BYTE, ADDR, D[DATA_BYTES-1] … D[0] (MSB byte first), CHK.
- CHK must equal ADDR XOR all data bytes.
- Reset values: reg_wr_en=0, reg_addr=0, reg_wr_data=0, pkt_err=0, err_count=0, busy=0, state=IDLE, byte counter=0, running XOR=0.
- States:
  - IDLE: on rx_valid with rx_byte==SYNC_BYTE, go to ADDR. Other bytes are discarded silently, with no error.
  - ADDR: on rx_valid, latch reg_addr, set XOR=rx_byte, clear byte counter, go to DATA. A byte equal to SYNC_BYTE here is a valid address; there is no resync.
  - DATA: on each rx_valid, shift rx_byte into reg_wr_data from the LSB end (first byte lands in the MSB after DATA_BYTES shifts) and XOR it in. After byte DATA_BYTES-1, go to CHK.
  - CHK: on rx_valid, if rx_byte==XOR, assert reg_wr_en on the next cycle and go to WRITE. Otherwise pulse pkt_err and go to IDLE.
  - WRITE: hold reg_wr_en, reg_addr and reg_wr_data stable. The transfer completes in the cycle where reg_wr_en && reg_wr_ready. On the following cycle reg_wr_en=0 and state=IDLE.
- Latency: reg_wr_en rises 1 clk after the CHK rx_valid pulse. If reg_wr_ready is already high, there is exactly one reg_wr_en cycle.
- Overrun: an rx_valid arriving while in WRITE is dropped and pkt_err pulses. The pending write still completes.
- Simultaneous events: an rx_valid in the same cycle as the WRITE handshake counts as overrun (dropped). An rx_valid in IDLE is always processed.
- pkt_err is exactly one cycle wide per error event.
- err_count increments on each pkt_err and saturates at 8'hFF (no wrap).
- reg_addr and reg_wr_data are only guaranteed valid while reg_wr_en=1.
- reset_n asserted mid-packet or mid-WRITE: reg_wr_en drops immediately (async) and all state clears. The partial packet is lost with no error counted.

Optional Feature:
UART_CMD_TIMEOUT_EN
- Defined: a counter of at least clog2(TIMEOUT_CLKS+1) bits clears on every rx_valid and on entry to ADDR. It counts while in ADDR, DATA or CHK. On reaching TIMEOUT_CLKS with no byte, it pulses pkt_err, increments err_count and returns to IDLE. The counter does not run in IDLE or WRITE.
- Undefined: no counter is instantiated and the block waits indefinitely for the next byte of a packet.

Test Plan:
- Bytes A5 10 12 34 36, reg_wr_ready=1 -> one reg_wr_en cycle with reg_addr=8'h10, reg_wr_data=16'h1234; pkt_err never asserts; busy returns to 0.
- Bytes 00 FF 55 A5 10 12 34 36 -> leading garbage is ignored; one write of 16'h1234 to 8'h10; err_count stays 0.
- Bytes A5 10 12 34 37 -> no reg_wr_en; one pkt_err pulse; err_count=1; the next good packet writes normally.
- reg_wr_ready held low for 20 clks after a good packet, with rx_byte 8'hA5 pulsed during the wait -> reg_wr_en and data stay stable; the byte is dropped; pkt_err pulses once; the write completes when ready rises.
- With UART_CMD_TIMEOUT_EN and TIMEOUT_CLKS=100: send A5 10, then wait 100 clks -> pkt_err pulses and state returns to IDLE. Then send A5 20 AB CD 46 -> write to 8'h20 with data 16'hABCD.
- Assert reset_n low after A5 10 12, then release and send a full good packet -> no stale write occurs; only the new packet is written; err_count=0.

Source files
------------

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder
// Parses framed command packets from the UART receiver byte stream:
//   SYNC_BYTE, ADDR, D[DATA_BYTES-1] .. D[0], CHK  (CHK = ADDR ^ all data bytes)
// A packet that checks out becomes one valid/ready register write. Checksum
// failures and bytes arriving while a write is still pending pulse pkt_err
// and bump a saturating error counter.
//
// Optional build macro UART_CMD_TIMEOUT_EN: when defined, an inter-byte idle
// counter aborts a packet after TIMEOUT_CLKS clocks with no byte. When it is
// undefined, the decoder waits indefinitely for the rest of a packet.

module uart_cmd_decoder #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         DATA_BYTES   = 2,
  parameter int         TIMEOUT_CLKS = 50000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [7:0]                rx_byte,
  input  logic                      rx_valid,
  output logic                      reg_wr_en,
  output logic [7:0]                reg_addr,
  output logic [8*DATA_BYTES-1:0]   reg_wr_data,
  input  logic                      reg_wr_ready,
  output logic                      pkt_err,
  output logic [7:0]                err_count,
  output logic                      busy
);

  localparam int WD = 8 * DATA_BYTES;

  // Index of the last payload byte; the counter only needs to reach 3.
  localparam logic [1:0] LAST_IDX = 2'(DATA_BYTES - 1);

  // Reject parameter values the datapath was not built for.
  if (DATA_BYTES < 1 || DATA_BYTES > 4 || TIMEOUT_CLKS < 1) begin : g_bad_param
    $error("uart_cmd_decoder: DATA_BYTES must be 1..4 and TIMEOUT_CLKS >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_CHK   = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [7:0]      xor_q, xor_d;
  logic            reg_wr_en_q, reg_wr_en_d;
  logic [7:0]      reg_addr_q, reg_addr_d;
  logic [WD-1:0]   reg_wr_data_q, reg_wr_data_d;
  logic            pkt_err_q, pkt_err_d;
  logic [7:0]      err_count_q, err_count_d;
  logic            busy_q, busy_d;

  logic            err_event;
  logic            timeout_hit;
  logic            in_packet;
  logic [WD-1:0]   data_shifted;

  // States in which a packet is partially received (timeout applies here).
  assign in_packet = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_CHK);

  // Payload arrives MSB byte first, so each new byte enters at the LSB end.
  if (DATA_BYTES == 1) begin : g_shift_one
    assign data_shifted = rx_byte;
  end else begin : g_shift_many
    assign data_shifted = {reg_wr_data_q[WD-9:0], rx_byte};
  end

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CLKS - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Idle-clock counter: runs only mid-packet, cleared by every received byte.
  always_comb begin
    to_cnt_d    = '0;
    timeout_hit = 1'b0;
    if (in_packet && !rx_valid) begin
      if (to_cnt_q == TO_LIMIT) begin
        timeout_hit = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
  end

  // Register the idle-clock counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  // Without the timeout, a packet in progress waits forever for its next byte.
  assign timeout_hit = 1'b0;
`endif

  // Packet parser next-state and output computation.
  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    xor_d         = xor_q;
    reg_wr_en_d   = reg_wr_en_q;
    reg_addr_d    = reg_addr_q;
    reg_wr_data_d = reg_wr_data_q;
    err_event     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Anything other than the sync marker is line noise; drop it quietly.
        if (rx_valid && rx_byte == SYNC_BYTE) begin
          state_d = S_ADDR;
        end
      end

      S_ADDR: begin
        // A sync-valued byte here is simply an address; no resynchronisation.
        if (rx_valid) begin
          reg_addr_d = rx_byte;
          xor_d      = rx_byte;
          byte_cnt_d = 2'd0;
          state_d    = S_DATA;
        end else if (timeout_hit) begin
          err_event = 1'b1;
          state_d   = S_IDLE;
        end
      end

      S_DATA: begin
        if (rx_valid) begin
          reg_wr_data_d = data_shifted;
          xor_d         = xor_q ^ rx_byte;
          if (byte_cnt_q == LAST_IDX) begin
            state_d = S_CHK;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else if (timeout_hit) begin
          err_event = 1'b1;
          state_d   = S_IDLE;
        end
      end

      S_CHK: begin
        if (rx_valid) begin
          if (rx_byte == xor_q) begin
            reg_wr_en_d = 1'b1;
            state_d     = S_WRITE;
          end else begin
            err_event = 1'b1;
            state_d   = S_IDLE;
          end
        end else if (timeout_hit) begin
          err_event = 1'b1;
          state_d   = S_IDLE;
        end
      end

      S_WRITE: begin
        // A byte arriving now cannot be buffered: drop it and flag overrun,
        // even if the handshake completes in this same cycle.
        if (rx_valid) begin
          err_event = 1'b1;
        end
        if (reg_wr_en_q && reg_wr_ready) begin
          reg_wr_en_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        reg_wr_en_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase

    pkt_err_d = err_event;

    // Saturate rather than wrap so a flood of errors stays visible.
    err_count_d = err_count_q;
    if (err_event && err_count_q != 8'hFF) begin
      err_count_d = err_count_q + 8'd1;
    end

    busy_d = (state_d != S_IDLE);
  end

  // Single state register for the parser and all of its registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      byte_cnt_q    <= 2'd0;
      xor_q         <= 8'd0;
      reg_wr_en_q   <= 1'b0;
      reg_addr_q    <= 8'd0;
      reg_wr_data_q <= '0;
      pkt_err_q     <= 1'b0;
      err_count_q   <= 8'd0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      xor_q         <= xor_d;
      reg_wr_en_q   <= reg_wr_en_d;
      reg_addr_q    <= reg_addr_d;
      reg_wr_data_q <= reg_wr_data_d;
      pkt_err_q     <= pkt_err_d;
      err_count_q   <= err_count_d;
      busy_q        <= busy_d;
    end
  end

  assign reg_wr_en   = reg_wr_en_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wr_data = reg_wr_data_q;
  assign pkt_err     = pkt_err_q;
  assign err_count   = err_count_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder
// Directed byte-stream stimulus against uart_cmd_decoder. A packet-level
// reference model predicts every output cycle by cycle; a compare process
// checks the DUT each negedge, and literal expectations pin the model.
// Honours UART_CMD_TIMEOUT_EN the same way the design does.

module tb_uart_cmd_decoder;

  localparam int DB = 2;
  localparam int W  = 8 * DB;
  localparam int TO = 100;

  logic           clk;
  logic           reset_n;
  logic [7:0]     rx_byte;
  logic           rx_valid;
  logic           reg_wr_en;
  logic [7:0]     reg_addr;
  logic [W-1:0]   reg_wr_data;
  logic           reg_wr_ready;
  logic           pkt_err;
  logic [7:0]     err_count;
  logic           busy;

  uart_cmd_decoder #(
    .SYNC_BYTE    (8'hA5),
    .DATA_BYTES   (DB),
    .TIMEOUT_CLKS (TO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .reg_wr_en    (reg_wr_en),
    .reg_addr     (reg_addr),
    .reg_wr_data  (reg_wr_data),
    .reg_wr_ready (reg_wr_ready),
    .pkt_err      (pkt_err),
    .err_count    (err_count),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (packet level) ----------------
  logic           m_active;    // sync seen, collecting the packet body
  logic [7:0]     m_pkt[$];    // addr, data bytes, chk as received
  logic           m_wr_en;
  logic [7:0]     m_addr;
  logic [W-1:0]   m_data;
  logic           m_err;
  int             m_cnt;
  int             m_idle;
  logic           m_ev;
  logic           m_was_wr;
  logic [7:0]     m_x;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active = 1'b0;
      m_pkt.delete();
      m_wr_en  = 1'b0;
      m_addr   = 8'd0;
      m_data   = '0;
      m_err    = 1'b0;
      m_cnt    = 0;
      m_idle   = 0;
    end else begin
      m_ev     = 1'b0;
      m_was_wr = m_wr_en;
      if (m_was_wr && reg_wr_ready) m_wr_en = 1'b0;
      if (rx_valid) begin
        m_idle = 0;
        if (m_was_wr) begin
          m_ev = 1'b1;
        end else if (!m_active) begin
          if (rx_byte == 8'hA5) begin
            m_active = 1'b1;
            m_pkt.delete();
          end
        end else begin
          m_pkt.push_back(rx_byte);
          if (m_pkt.size() == DB + 2) begin
            m_x = 8'd0;
            for (int i = 0; i <= DB; i++) m_x = m_x ^ m_pkt[i];
            if (m_x == m_pkt[DB+1]) begin
              m_wr_en = 1'b1;
              m_addr  = m_pkt[0];
              m_data  = '0;
              for (int i = 1; i <= DB; i++) m_data = (m_data << 8) | W'(m_pkt[i]);
            end else begin
              m_ev = 1'b1;
            end
            m_active = 1'b0;
          end
        end
      end else if (m_active) begin
`ifdef UART_CMD_TIMEOUT_EN
        m_idle = m_idle + 1;
        if (m_idle == TO) begin
          m_ev     = 1'b1;
          m_active = 1'b0;
          m_idle   = 0;
        end
`endif
      end
      m_err = m_ev;
      if (m_ev && m_cnt < 255) m_cnt = m_cnt + 1;
    end
  end

  // ---------------- checking ----------------
  int              n_pass;
  int              n_total;
  int              err_pulses;
  logic [8+W-1:0]  wr_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      check("wr_en", 32'(reg_wr_en), 32'(m_wr_en));
      check("busy", 32'(busy), 32'(m_active || m_wr_en));
      check("pkt_err", 32'(pkt_err), 32'(m_err));
      check("err_count", 32'(err_count), 32'(m_cnt));
      if (m_wr_en) begin
        check("addr", 32'(reg_addr), 32'(m_addr));
        check("data", 32'(reg_wr_data), 32'(m_data));
      end
      if (pkt_err === 1'b1) err_pulses++;
      if (reg_wr_en === 1'b1 && reg_wr_ready === 1'b1) begin
        wr_log.push_back({reg_addr, reg_wr_data});
        $display("write addr=%0h data=%0h at %0t", reg_addr, reg_wr_data, $time);
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  // Inputs change 2 time units after a rising edge, far from the sample point.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    idle(1);
    rx_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [7:0] d1,
                          input logic [7:0] d0, input logic [7:0] c);
    send(8'hA5);
    send(a);
    send(d1);
    send(d0);
    send(c);
  endtask

  task automatic expect_one_write(input string name, input logic [8+W-1:0] exp);
    check({name, "_nwr"}, 32'(wr_log.size()), 32'd1);
    if (wr_log.size() >= 1) check({name, "_wr"}, 32'(wr_log[0]), 32'(exp));
    wr_log.delete();
  endtask

  initial begin
    n_pass       = 0;
    n_total      = 0;
    err_pulses   = 0;
    reset_n      = 1'b0;
    rx_valid     = 1'b0;
    rx_byte      = 8'h00;
    reg_wr_ready = 1'b1;
    fork
      compare_loop();
    join_none

    idle(2);
    check("rst_wr_en", 32'(reg_wr_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_pkt_err", 32'(pkt_err), 32'd0);
    check("rst_data", 32'(reg_wr_data), 32'd0);
    reset_n = 1'b1;
    idle(2);

    // Basic good packet, ready already high: exactly one write cycle.
    send_pkt(8'h10, 8'h12, 8'h34, 8'h36);
    check("t1_latency", 32'(reg_wr_en), 32'd1);
    idle(1);
    check("t1_one_cycle", 32'(reg_wr_en), 32'd0);
    idle(2);
    expect_one_write("t1", {8'h10, 16'h1234});
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_errs", 32'(err_pulses), 32'd0);

    // Leading garbage is ignored silently.
    send(8'h00);
    send(8'hFF);
    send(8'h55);
    send_pkt(8'h10, 8'h12, 8'h34, 8'h36);
    idle(3);
    expect_one_write("t2", {8'h10, 16'h1234});
    check("t2_err_count", 32'(err_count), 32'd0);

    // Bad checksum, then a good packet.
    send_pkt(8'h10, 8'h12, 8'h34, 8'h37);
    idle(3);
    check("t3_nwr", 32'(wr_log.size()), 32'd0);
    check("t3_err_count", 32'(err_count), 32'd1);
    check("t3_errs", 32'(err_pulses), 32'd1);
    send_pkt(8'h20, 8'hAB, 8'hCD, 8'h46);
    idle(3);
    expect_one_write("t3b", {8'h20, 16'hABCD});

    // Back-pressure with an overrun byte during the wait.
    reg_wr_ready = 1'b0;
    send_pkt(8'h10, 8'h12, 8'h34, 8'h36);
    idle(5);
    send(8'hA5);
    idle(12);
    check("t4_held", 32'(reg_wr_en), 32'd1);
    check("t4_addr", 32'(reg_addr), 32'h10);
    check("t4_data", 32'(reg_wr_data), 32'h1234);
    reg_wr_ready = 1'b1;
    idle(3);
    expect_one_write("t4", {8'h10, 16'h1234});
    check("t4_err_count", 32'(err_count), 32'd2);
    check("t4_busy", 32'(busy), 32'd0);

`ifdef UART_CMD_TIMEOUT_EN
    // Stalled packet is abandoned after the idle limit.
    send(8'hA5);
    send(8'h10);
    idle(TO + 5);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_err_count", 32'(err_count), 32'd3);
    send_pkt(8'h20, 8'hAB, 8'hCD, 8'h46);
    idle(3);
    expect_one_write("t5", {8'h20, 16'hABCD});
`else
    // Without the timeout a stalled packet simply resumes.
    send(8'hA5);
    send(8'h10);
    idle(200);
    check("t5_busy", 32'(busy), 32'd1);
    send(8'h12);
    send(8'h34);
    send(8'h36);
    idle(3);
    expect_one_write("t5", {8'h10, 16'h1234});
    check("t5_err_count", 32'(err_count), 32'd2);
`endif

    // Error counter saturates at FF.
    repeat (260) send_pkt(8'h10, 8'h12, 8'h34, 8'h37);
    idle(3);
    check("t6_sat", 32'(err_count), 32'hFF);
    check("t6_nwr", 32'(wr_log.size()), 32'd0);

    // Reset mid-packet.
    send(8'hA5);
    send(8'h10);
    send(8'h12);
    #1;
    reset_n = 1'b0;
    #1;
    check("t7_rst_busy", 32'(busy), 32'd0);
    check("t7_rst_err_count", 32'(err_count), 32'd0);
    idle(2);
    reset_n = 1'b1;
    idle(2);

    // Reset mid-WRITE: request drops immediately and the write is lost.
    reg_wr_ready = 1'b0;
    send_pkt(8'h10, 8'h12, 8'h34, 8'h36);
    idle(2);
    check("t7_in_write", 32'(reg_wr_en), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("t7_async_drop", 32'(reg_wr_en), 32'd0);
    idle(2);
    reg_wr_ready = 1'b1;
    reset_n = 1'b1;
    idle(2);
    check("t7_nwr", 32'(wr_log.size()), 32'd0);

    send_pkt(8'h30, 8'h12, 8'h34, 8'h16);
    idle(3);
    expect_one_write("t7", {8'h30, 16'h1234});
    check("t7_err_count", 32'(err_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
